// File: rtl/pid_encode_pkg.sv
// Shared definitions for the USB transmit-side packet framer:
// PID codes and classes, FSM state encoding and CRC16-USB constants.
package pid_encode_pkg;

    localparam int MAX_LEN_DEFAULT = 64;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

    // Low nibble of the wire PID byte
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        PID_CLASS_SPECIAL   = 2'b00,
        PID_CLASS_TOKEN     = 2'b01,
        PID_CLASS_HANDSHAKE = 2'b10,
        PID_CLASS_DATA      = 2'b11
    } pid_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_PID,
        ST_LOAD,
        ST_SEND_DATA,
        ST_SEND_CRC_LO,
        ST_SEND_CRC_HI,
        ST_DONE
    } state_t;

    function automatic pid_class_t pid_class(input logic [3:0] pid);
        return pid_class_t'(pid[1:0]);
    endfunction

    // The upper nibble on the wire is the one's complement check field
    function automatic logic [7:0] pid_wire(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/pid_encode_if.sv
// Request, TX FIFO and serializer handshake signals of the packet framer.
// The framer uses the slave modport; the requesting logic uses master.
interface pid_encode_if;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] tx_length;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_pid, tx_length, fifo_data, fifo_empty, tx_ready,
        input  fifo_read, tx_byte, tx_valid, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_pid, tx_length, fifo_data, fifo_empty, tx_ready,
        output fifo_read, tx_byte, tx_valid, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/pid_encode_crc16_usb_byte.sv
// Combinational CRC16-USB update for one byte, LSB first, reflected poly.
// Unrolled as eight chained single-bit shift stages.
module crc16_usb_byte
    import pid_encode_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [8:0][15:0] stage;

    // Folding the byte into the low bits up front lets each stage test bit 0 only
    assign stage[0] = crc_in ^ {8'h00, data};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][0] ? ((stage[gi] >> 1) ^ CRC_POLY_REFL)
                                              : (stage[gi] >> 1);
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/pid_encode.sv
// Transmit packet framer: emits PID, FIFO payload and complemented CRC16
// over a valid/ready byte stream towards the serializer.
module pid_encode
    import pid_encode_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic         clk,
    input  logic         n_rst,
    pid_encode_if.slave  bus
);

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    state_t      state_reg, state_next;
    logic        hs_reg, hs_next;
    logic [6:0]  len_reg, len_next;
    logic [6:0]  count_reg, count_next;
    logic [15:0] crc_reg, crc_next;
    logic [7:0]  byte_reg, byte_next;
    logic        error_reg, error_next;

    logic        valid_int;
    logic        read_int;
    logic        start_ok;
    logic [15:0] crc_with_byte;

    crc16_usb_byte u_crc (
        .crc_in  (crc_reg),
        .data    (bus.fifo_data),
        .crc_out (crc_with_byte)
    );

    assign start_ok = (pid_class(bus.tx_pid) == PID_CLASS_HANDSHAKE) ||
                      ((pid_class(bus.tx_pid) == PID_CLASS_DATA) &&
                       (bus.tx_length <= MAX_LEN_W));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
            hs_reg    <= 1'b0;
            len_reg   <= '0;
            count_reg <= '0;
            crc_reg   <= CRC_INIT;
            byte_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hs_reg    <= hs_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            crc_reg   <= crc_next;
            byte_reg  <= byte_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hs_next    = hs_reg;
        len_next   = len_reg;
        count_next = count_reg;
        crc_next   = crc_reg;
        byte_next  = byte_reg;
        error_next = 1'b0;
        valid_int  = 1'b0;
        read_int   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    if (start_ok) begin
                        state_next = ST_SEND_PID;
                        hs_next    = (pid_class(bus.tx_pid) == PID_CLASS_HANDSHAKE);
                        len_next   = bus.tx_length;
                        count_next = '0;
                        crc_next   = CRC_INIT;
                        byte_next  = pid_wire(bus.tx_pid);
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end

            ST_SEND_PID: begin
                valid_int = 1'b1;
                if (bus.tx_ready) begin
                    if (hs_reg) begin
                        state_next = ST_DONE;
                    end else if (len_reg == 7'd0) begin
                        state_next = ST_SEND_CRC_LO;
                        byte_next  = ~crc_reg[7:0];
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end

            // The FIFO is only popped here, so a byte is read exactly once
            ST_LOAD: begin
                if (!bus.fifo_empty) begin
                    read_int   = 1'b1;
                    byte_next  = bus.fifo_data;
                    crc_next   = crc_with_byte;
                    state_next = ST_SEND_DATA;
                end else begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            ST_SEND_DATA: begin
                valid_int = 1'b1;
                if (bus.tx_ready) begin
                    count_next = count_reg + 7'd1;
                    if (count_reg + 7'd1 == len_reg) begin
                        state_next = ST_SEND_CRC_LO;
                        byte_next  = ~crc_reg[7:0];
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end

            ST_SEND_CRC_LO: begin
                valid_int = 1'b1;
                if (bus.tx_ready) begin
                    state_next = ST_SEND_CRC_HI;
                    byte_next  = ~crc_reg[15:8];
                end
            end

            ST_SEND_CRC_HI: begin
                valid_int = 1'b1;
                if (bus.tx_ready) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_byte   = byte_reg;
    assign bus.tx_valid  = valid_int;
    assign bus.fifo_read = read_int;
    assign bus.tx_busy   = (state_reg != ST_IDLE);
    assign bus.tx_done   = (state_reg == ST_DONE);
    assign bus.tx_error  = error_reg;

endmodule

// File: tb/tb_pid_encode.sv
// Scoreboard bench for pid_encode: expected bytes are queued when a packet
// is requested and popped as the framer transfers them to the serializer.
module tb_pid_encode;
    import pid_encode_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pid_encode_if bus ();

    pid_encode #(.MAX_LEN(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];

    int cyc = 0, ph = 0, ready_mode = 0;
    int xfer_count = 0, rd_count = 0, done_count = 0, err_count = 0;
    int start_cyc = 0, last_xfer_cyc = 0, done_cyc = 0, err_cyc = 0;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Monitor samples at negedge; FIFO model and tx_ready update just after posedge
    always begin
        logic pop_now;
        @(negedge clk);
        cyc++;
        ph++;
        pop_now = 1'b0;
        if (n_rst) begin
            if (bus.tx_start && !bus.tx_busy) start_cyc = cyc;
            if (bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    check_value("spurious_valid", 32'(bus.tx_valid), 32'd0);
                end else begin
                    check_value("tx_byte", 32'(bus.tx_byte), 32'(exp_q[0]));
                    if (bus.tx_ready) begin
                        void'(exp_q.pop_front());
                        xfer_count++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
            if (bus.fifo_read) begin
                rd_count++;
                pop_now = 1'b1;
            end
            if (bus.tx_done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (bus.tx_error) begin
                err_count++;
                err_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        if (ready_mode == 0) bus.tx_ready = 1'b1;
        else bus.tx_ready = ((ph % 20) >= 8 && (ph % 20) < 13) ? 1'b0 : ((ph % 2) == 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
        check_value({tag, "_busy"},  32'(bus.tx_busy),  32'd0);
        check_value({tag, "_done"},  32'(bus.tx_done),  32'd0);
        check_value({tag, "_error"}, 32'(bus.tx_error), 32'd0);
        check_value({tag, "_read"},  32'(bus.fifo_read), 32'd0);
        check_value({tag, "_byte"},  32'(bus.tx_byte),  32'd0);
    endtask

    task automatic send_packet(input string name, input logic [3:0] pid,
                               input logic [6:0] len, input int nfifo,
                               input logic [7:0] base, input bit poke);
        bit         is_data, accept, exp_done, finished;
        int         npay, exp_rd, d0, e0, r0;
        logic [15:0] crc;
        is_data  = (pid[1:0] == 2'b11);
        accept   = (pid[1:0] == 2'b10) || (is_data && len <= 7'd64);
        npay     = (nfifo < int'(len)) ? nfifo : int'(len);
        exp_done = accept && !(is_data && nfifo < int'(len));
        exp_rd   = (accept && is_data) ? npay : 0;

        for (int i = 0; i < nfifo; i++) fifo_q.push_back(base + 8'(i));
        if (accept) begin
            exp_q.push_back({~pid, pid});
            if (is_data) begin
                crc = 16'hFFFF;
                for (int i = 0; i < npay; i++) begin
                    exp_q.push_back(base + 8'(i));
                    crc = crc_step(crc, base + 8'(i));
                end
                if (exp_done) begin
                    exp_q.push_back(~crc[7:0]);
                    exp_q.push_back(~crc[15:8]);
                end
            end
        end
        tick();
        d0 = done_count; e0 = err_count; r0 = rd_count;
        bus.tx_pid    = pid;
        bus.tx_length = len;
        bus.tx_start  = 1'b1;
        tick();
        bus.tx_start  = 1'b0;
        check_value({name, "_busy_after_start"}, 32'(bus.tx_busy), 32'(accept));
        finished = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_count > d0 || err_count > e0) begin
                finished = 1'b1;
                break;
            end
            if (poke && i == 3) begin
                bus.tx_pid   = PID_ACK;
                bus.tx_start = 1'b1;
            end else begin
                bus.tx_start = 1'b0;
            end
            tick();
        end
        bus.tx_start = 1'b0;
        check_value({name, "_finished"}, 32'(finished), 32'd1);
        tick();
        tick();
        check_value({name, "_done_cnt"}, 32'(done_count - d0), 32'(exp_done));
        check_value({name, "_err_cnt"},  32'(err_count - e0),  32'(!exp_done));
        check_value({name, "_reads"},    32'(rd_count - r0),   32'(exp_rd));
        check_value({name, "_left_exp"}, 32'(exp_q.size()),    32'd0);
        check_value({name, "_left_fifo"}, 32'(fifo_q.size()),  32'(nfifo - exp_rd));
        check_value({name, "_busy_end"}, 32'(bus.tx_busy),     32'd0);
        if (exp_done)
            check_value({name, "_done_lat"}, 32'(done_cyc - last_xfer_cyc), 32'd1);
        if (!accept)
            check_value({name, "_err_lat"}, 32'(err_cyc - start_cyc), 32'd1);
        $display("pkt %s pid=%b len=%0d reads=%0d done=%0d err=%0d",
                 name, pid, len, rd_count - r0, done_count - d0, err_count - e0);
        fifo_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int x0, d0, e0;
        bit reached;
        bus.tx_start  = 1'b0;
        bus.tx_pid    = 4'h0;
        bus.tx_length = 7'd0;
        n_rst = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        n_rst = 1'b1;
        tick();

        send_packet("ack",        PID_ACK,   7'd100, 0, 8'h00, 1'b0);
        send_packet("data0_len0", PID_DATA0, 7'd0,   0, 8'h00, 1'b0);
        send_packet("data1_len9", PID_DATA1, 7'd9,   9, 8'h31, 1'b0);
        ready_mode = 1;
        ph = 0;
        send_packet("data1_stall", PID_DATA1, 7'd9,  9, 8'h31, 1'b0);
        ready_mode = 0;
        send_packet("out_reject", PID_OUT,   7'd0,   0, 8'h00, 1'b0);
        send_packet("len65",      PID_DATA0, 7'd65,  0, 8'h00, 1'b0);
        send_packet("underrun",   PID_DATA0, 7'd4,   2, 8'hA0, 1'b0);

        // Abort mid-packet with reset: outputs clear at once, no pulses
        for (int i = 0; i < 9; i++) fifo_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'h4B);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        tick();
        x0 = xfer_count;
        bus.tx_pid    = PID_DATA1;
        bus.tx_length = 7'd9;
        bus.tx_start  = 1'b1;
        tick();
        bus.tx_start  = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (xfer_count >= x0 + 3) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check_value("abort_reached", 32'(reached), 32'd1);
        check_value("abort_busy_before", 32'(bus.tx_busy), 32'd1);
        d0 = done_count;
        e0 = err_count;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        tick();
        tick();
        fifo_q.delete();
        exp_q.delete();
        tick();
        n_rst = 1'b1;
        tick();
        tick();
        check_value("abort_no_done", 32'(done_count - d0), 32'd0);
        check_value("abort_no_err",  32'(err_count - e0),  32'd0);
        $display("pkt abort transfers=%0d", xfer_count - x0);

        send_packet("busy_poke", PID_DATA1, 7'd3, 3, 8'h10, 1'b1);
        send_packet("nak",       PID_NAK,   7'd0, 0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
